// File: rtl/hazard_sched_pkg.sv
// hazard_sched_pkg: shared definitions for the ID-stage hazard scheduler.
//   REG_ADDR_W   - default register index width
//   kind_t       - id_kind encodings (ALU, LOAD, MULDIV, STORE/other)
//   state_t      - scheduler FSM states
//   is_long_latency() - true for instruction kinds tracked by the scoreboard
package hazard_sched_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      KIND_ALU    = 2'd0,
      KIND_LOAD   = 2'd1,
      KIND_MULDIV = 2'd2,
      KIND_OTHER  = 2'd3
   } kind_t;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   // Only loads and mul/div produce results later than EX, so only they
   // need a pending-write bit.
   function automatic logic is_long_latency(input logic [1:0] kind);
      return (kind == KIND_LOAD) || (kind == KIND_MULDIV);
   endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// hazard_sched_if: pipeline <-> hazard scheduler signal bundle.
//   master modport: pipeline side (drives ID/EX/MEM/WB status, reads controls)
//   slave modport : scheduler side (reads status, drives stall/flush controls)
interface hazard_sched_if
   import hazard_sched_pkg::*;
#(
   parameter int AW = REG_ADDR_W
);
   localparam int NREG = 1 << AW;

   // ID-stage instruction
   logic            id_valid;
   logic [AW-1:0]   id_rs1;
   logic [AW-1:0]   id_rs2;
   logic            id_rs1_used;
   logic            id_rs2_used;
   logic [AW-1:0]   id_rd;
   logic            id_rd_wen;
   logic [1:0]      id_kind;
   // Later-stage status
   logic            redirect;
   logic            mem_req;
   logic            mem_ready;
   logic            mdu_done;
   logic            wb_valid;
   logic            wb_wen;
   logic [AW-1:0]   wb_rd;
   // Scheduler controls / status
   logic            id_fire;
   logic            stall_pc;
   logic            stall_if_id;
   logic            freeze_ex_mem;
   logic            bubble_id_ex;
   logic            flush_if_id;
   logic [NREG-1:0] sb_busy;
   logic            mdu_busy;
   logic            mem_timeout;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_rd_wen, id_kind, redirect, mem_req, mem_ready, mdu_done,
             wb_valid, wb_wen, wb_rd,
      input  id_fire, stall_pc, stall_if_id, freeze_ex_mem, bubble_id_ex,
             flush_if_id, sb_busy, mdu_busy, mem_timeout
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_rd_wen, id_kind, redirect, mem_req, mem_ready, mdu_done,
             wb_valid, wb_wen, wb_rd,
      output id_fire, stall_pc, stall_if_id, freeze_ex_mem, bubble_id_ex,
             flush_if_id, sb_busy, mdu_busy, mem_timeout
   );

endinterface

// File: rtl/hazard_sched_reg_scoreboard.sv
// hazard_sched_reg_scoreboard: pending-write bit per architectural register.
//   clk, rst          - clock, asynchronous active-high reset
//   set_en, set_idx   - mark a register as awaiting a long-latency result
//   clr_en, clr_idx   - register-file write retires the pending bit
//   rd_idx0..2, hit0..2 - three lookup ports (rs1, rs2, rd)
//   busy              - full pending-bit vector
module hazard_sched_reg_scoreboard
   import hazard_sched_pkg::*;
#(
   parameter int AW = REG_ADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               set_en,
   input  logic [AW-1:0]      set_idx,
   input  logic               clr_en,
   input  logic [AW-1:0]      clr_idx,
   input  logic [AW-1:0]      rd_idx0,
   input  logic [AW-1:0]      rd_idx1,
   input  logic [AW-1:0]      rd_idx2,
   output logic               hit0,
   output logic               hit1,
   output logic               hit2,
   output logic [(1<<AW)-1:0] busy
);
   localparam int N = 1 << AW;

   logic [N-1:0] busy_reg;
   logic [N-1:0] busy_next;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         if (gi == 0) begin : g_zero
            // x0 is hardwired, so it can never be pending.
            assign busy_next[gi] = 1'b0;
         end else begin : g_reg
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_en && (set_idx == AW'(gi));
            assign clr_hit = clr_en && (clr_idx == AW'(gi));
            // A new writer issuing in the same cycle as an old write retiring
            // must stay pending, so set dominates.
            assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   assign hit0 = busy_reg[rd_idx0];
   assign hit1 = busy_reg[rd_idx1];
   assign hit2 = busy_reg[rd_idx2];
   assign busy = busy_reg;

endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: decides each cycle whether the ID instruction issues, stalls
// or is flushed; freezes the back end during data-memory waits.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - hazard_sched_if.slave: ID instruction, redirect, mem handshake,
//              mdu completion, WB write in; issue/stall/freeze/bubble/flush,
//              scoreboard, mdu_busy and mem_timeout out
module hazard_sched
   import hazard_sched_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_W,
   parameter int MEM_TIMEOUT    = 255
) (
   input  logic          clk,
   input  logic          rst,
   hazard_sched_if.slave bus
);
   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             mdu_busy_reg, mdu_busy_next;
   logic             mem_timeout_reg;

   logic to_hit, freeze, hazard, fire, sb_set;
   logic hit_rs1, hit_rs2, hit_rd;

   hazard_sched_reg_scoreboard #(.AW(REG_ADDR_WIDTH)) u_sb (
      .clk     (clk),
      .rst     (rst),
      .set_en  (sb_set),
      .set_idx (bus.id_rd),
      .clr_en  (bus.wb_valid && bus.wb_wen),
      .clr_idx (bus.wb_rd),
      .rd_idx0 (bus.id_rs1),
      .rd_idx1 (bus.id_rs2),
      .rd_idx2 (bus.id_rd),
      .hit0    (hit_rs1),
      .hit1    (hit_rs2),
      .hit2    (hit_rd),
      .busy    (bus.sb_busy)
   );

   assign to_hit = (state_reg == ST_MEM_WAIT) && (cnt_reg == CNT_LAST);

   // The final timeout cycle is released even without mem_ready.
   assign freeze = ((state_reg == ST_RUN) && bus.mem_req && !bus.mem_ready) ||
                   ((state_reg == ST_MEM_WAIT) && !bus.mem_ready && !to_hit);

   assign hazard = (bus.id_rs1_used && (bus.id_rs1 != '0) && hit_rs1) ||
                   (bus.id_rs2_used && (bus.id_rs2 != '0) && hit_rs2) ||
                   (bus.id_rd_wen   && (bus.id_rd  != '0) && hit_rd)  ||
                   ((bus.id_kind == KIND_MULDIV) && mdu_busy_reg);

   assign fire = bus.id_valid && !freeze && (state_reg != ST_FLUSH) &&
                 !bus.redirect && !hazard;

   assign sb_set = fire && bus.id_rd_wen && (bus.id_rd != '0) &&
                   is_long_latency(bus.id_kind);

   // A redirect wins over a hazard stall: the ID instruction is being
   // discarded anyway, so the front end must be allowed to refetch.
   assign bus.id_fire       = fire;
   assign bus.freeze_ex_mem = freeze;
   assign bus.stall_pc      = freeze || (bus.id_valid && hazard && !bus.redirect);
   assign bus.stall_if_id   = freeze || (bus.id_valid && hazard && !bus.redirect);
   assign bus.bubble_id_ex  = !freeze && !fire;
   assign bus.flush_if_id   = bus.redirect && !freeze;
   assign bus.mdu_busy      = mdu_busy_reg;
   assign bus.mem_timeout   = mem_timeout_reg;

   // Busy through the mdu_done cycle; an issuing mul/div re-arms it.
   assign mdu_busy_next = (fire && (bus.id_kind == KIND_MULDIV)) ||
                          (mdu_busy_reg && !bus.mdu_done);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_RUN: begin
            if (freeze) begin
               state_next = ST_MEM_WAIT;
               cnt_next   = '0;
            end else if (bus.redirect) begin
               state_next = ST_FLUSH;
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_ready || to_hit) begin
               state_next = ST_RUN;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_FLUSH: begin
            // One refill bubble, then back to normal issue.
            state_next = ST_RUN;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_RUN;
         cnt_reg         <= '0;
         mdu_busy_reg    <= 1'b0;
         mem_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         mdu_busy_reg    <= mdu_busy_next;
         // mem_ready arriving on the last allowed cycle is a normal completion.
         mem_timeout_reg <= to_hit && !bus.mem_ready;
      end
   end

endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline hazard scheduler for the rvseed five-stage core. It sits beside the ID stage and decides each cycle whether the instruction in ID issues to EX, stalls or is flushed. It keeps a register scoreboard for long-latency writers (loads, mul/div), tracks the single mul/div unit as a structural resource, freezes the whole pipe while a data-memory access waits for `mem_ready`, and applies branch redirects. It replaces ad-hoc combinational stall logic with one registered point of control.

## Interface
- `REG_ADDR_WIDTH`, default `` `REG_ADDR_WIDTH`` (5): register index width.
- `MEM_TIMEOUT`, default 255: maximum number of MEM_WAIT cycles before forced release.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_rs1`, `id_rs2` in REG_ADDR_WIDTH: source indices.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in REG_ADDR_WIDTH, `id_rd_wen` in 1: destination index and write enable.
- `id_kind` in 2: 0 ALU, 1 LOAD, 2 MULDIV, 3 STORE/other.
- `redirect` in 1: branch/jump taken, resolved in EX.
- `mem_req` in 1, `mem_ready` in 1: MEM-stage access request and its completion.
- `mdu_done` in 1: mul/div result is accepted by WB this cycle.
- `wb_valid`, `wb_wen` in 1, `wb_rd` in REG_ADDR_WIDTH: register-file write this cycle.
- `id_fire` out 1: the ID instruction is issued to EX this cycle.
- `stall_pc`, `stall_if_id` out 1: hold the PC and the IF/ID register.
- `freeze_ex_mem` out 1: hold the ID/EX, EX/MEM and MEM/WB registers.
- `bubble_id_ex` out 1: load a NOP into ID/EX.
- `flush_if_id` out 1: invalidate IF/ID.
- `sb_busy` out 2^REG_ADDR_WIDTH: scoreboard pending-write bits.
- `mdu_busy` out 1: mul/div unit is occupied.
- `mem_timeout` out 1: one-cycle pulse when the timeout forces release.

## Operation
- State machine has three states: RUN, MEM_WAIT, FLUSH. Reset state is RUN.
- `freeze` = (RUN & `mem_req` & !`mem_ready`) | (MEM_WAIT & !`mem_ready` & !`to_hit`), where `to_hit` = (counter == MEM_TIMEOUT-1).
- `freeze` drives `freeze_ex_mem`, `stall_pc` and `stall_if_id`. While frozen, `id_fire`, `bubble_id_ex` and `flush_if_id` are all 0. The scoreboard still clears on WB writes.
- `hazard` is true when any of these holds:
  - RAW: (`id_rs1_used` & `id_rs1`≠0 & `sb_busy[id_rs1]`), or the same for rs2.
  - WAW: `id_rd_wen` & `id_rd`≠0 & `sb_busy[id_rd]`.
  - Structural: `id_kind`==MULDIV & `mdu_busy`. The cycle in which `mdu_done` is asserted still counts as busy.
- `id_fire` = `id_valid` & !`freeze` & state≠FLUSH & !`redirect` & !`hazard`.
- `stall_pc` and `stall_if_id` are also 1 when `id_valid` & `hazard` & !`redirect`.
- `bubble_id_ex` = !`freeze` & !`id_fire`.
- `flush_if_id` = `redirect` & !`freeze`. A redirect during a freeze is ignored; EX is held, so the redirect is re-presented later.
- State transitions:
  - RUN → MEM_WAIT on `freeze`.
  - RUN → FLUSH on `redirect`.
  - MEM_WAIT → RUN on `mem_ready` or `to_hit`.
  - FLUSH → RUN unconditionally, giving one extra bubble while the fetch refills.
- Scoreboard set: on `id_fire` & `id_rd_wen` & `id_rd`≠0 & `id_kind`∈{LOAD, MULDIV}, set `sb_busy[id_rd]`.
- Scoreboard clear: on `wb_valid` & `wb_wen`, clear `sb_busy[wb_rd]`. If set and clear hit the same index in the same cycle, set wins. Bit 0 is always 0.
- `mdu_busy` is set on `id_fire` of a MULDIV and cleared on `mdu_done`. If both happen in the same cycle, set wins.
- Timeout counter: cleared on entry to MEM_WAIT and incremented each MEM_WAIT cycle. `mem_timeout` pulses in the cycle after `to_hit`. `mem_ready` takes priority over `to_hit`: if both occur in the same cycle, there is no pulse.

## Timing
- Reset values: state RUN, `sb_busy` = 0, `mdu_busy` = 0, counter 0, `mem_timeout` 0. Combinational outputs then evaluate from RUN (with `id_valid`=0, `bubble_id_ex`=1).
- `id_fire`, the stall outputs, the freeze, the bubble and the flush are combinational, with zero latency from their inputs.
- Scoreboard, `mdu_busy`, state and `mem_timeout` are registered, so they are visible the cycle after the event.
- A load issued in cycle N blocks a dependent instruction from cycle N+1 until the cycle after its WB write.
- Asynchronous reset mid-MEM_WAIT or mid-FLUSH returns immediately to RUN with the scoreboard cleared. There is no pending-state recovery.

## Structure
- Shared defines file: `REG_ADDR_WIDTH`, the `id_kind` encodings (KIND_ALU/LOAD/MULDIV/OTHER) and the state encodings.
- Natural sub-module: `reg_scoreboard` (set/clear/lookup of `sb_busy`, three read ports). FSM, counter and stall logic live in the top.

## Test plan
- LOAD x5 fires, then ADD reading x5 in ID: `stall_pc`=1 and `bubble_id_ex`=1 each cycle until the cycle after `wb_rd`=5 & `wb_wen`, then `id_fire`=1.
- ADD using rs1=x0 with an `sb_busy` pattern nonzero elsewhere: `id_fire`=1. A LOAD to x0 leaves `sb_busy`=0.
- MULDIV issued, then a second MULDIV: blocked while `mdu_busy`, including the `mdu_done` cycle, and fires the cycle after.
- `mem_req`=1 with `mem_ready` low for 3 cycles: freeze high for those 3 cycles, state MEM_WAIT, ready in cycle 4 → freeze low, RUN next, no `mem_timeout`.
- `mem_ready` held low with MEM_TIMEOUT=4: freeze for 4 cycles, `mem_timeout` pulses once, state returns to RUN.
- `redirect` in RUN: `flush_if_id`=1 and `id_fire`=0, next cycle FLUSH with `bubble_id_ex`=1, then RUN. `redirect` during a freeze: `flush_if_id`=0.
